// File: rtl/prio_arbiter_pipe.sv
// N-channel priority arbiter with a single registered output stage.
// Starvation guard promotes channels that lose AGE_LIMIT times in a row.
module prio_arbiter_pipe #(
   parameter int N_CH      = 8,
   parameter int DATA_W    = 8,
   parameter int PRIO_W    = 8,
   parameter int AGE_LIMIT = 15,
   parameter int IDX_W     = $clog2(N_CH)
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     mode,
   input  logic [N_CH-1:0]          in_valid,
   input  logic [N_CH*DATA_W-1:0]   in_data,
   input  logic [N_CH*PRIO_W-1:0]   in_prio,
   output logic [N_CH-1:0]          in_ready,
   output logic                     out_valid,
   output logic [IDX_W-1:0]         out_idx,
   output logic [DATA_W-1:0]        out_data,
   output logic [PRIO_W-1:0]        out_prio,
   input  logic                     out_ready
);

   localparam int AGE_W = $clog2(AGE_LIMIT + 1);
   localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);

   logic [PRIO_W-1:0] max_prio;
   logic [N_CH-1:0]   aged_vec;
   logic [N_CH-1:0]   top_vec;
   logic [N_CH-1:0]   cand_vec;
   logic [N_CH-1:0]   upper_vec;
   logic [N_CH-1:0]   cand_upper;
   logic              any_aged;
   logic              use_rr;
   logic              load;
   logic [IDX_W-1:0]  g_idx;
   logic [IDX_W-1:0]  rr_ptr;
   logic [AGE_W-1:0]  age [N_CH];

   function automatic logic [IDX_W-1:0] lowest_set(input logic [N_CH-1:0] v);
      lowest_set = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (v[i]) lowest_set = IDX_W'(i);
      end
   endfunction

   always_comb begin
      max_prio = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (in_valid[i] && (in_prio[i*PRIO_W +: PRIO_W] > max_prio))
            max_prio = in_prio[i*PRIO_W +: PRIO_W];
      end
   end

   // Aged requesters override priority and are always served in circular order.
   always_comb begin
      aged_vec  = '0;
      top_vec   = '0;
      upper_vec = '0;
      for (int i = 0; i < N_CH; i++) begin
         aged_vec[i]  = in_valid[i] && (age[i] == AGE_MAX);
         top_vec[i]   = in_valid[i] && (in_prio[i*PRIO_W +: PRIO_W] == max_prio);
         upper_vec[i] = (IDX_W'(i) >= rr_ptr);
      end
      any_aged   = |aged_vec;
      cand_vec   = any_aged ? aged_vec : top_vec;
      use_rr     = mode || any_aged;
      cand_upper = cand_vec & upper_vec;
      if (use_rr && (|cand_upper))
         g_idx = lowest_set(cand_upper);
      else
         g_idx = lowest_set(cand_vec);
   end

   assign load     = reset_n && (|in_valid) && (!out_valid || out_ready);
   assign in_ready = load ? (N_CH'(1) << g_idx) : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_idx   <= '0;
         out_data  <= '0;
         out_prio  <= '0;
         rr_ptr    <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_idx   <= g_idx;
         out_data  <= in_data[g_idx*DATA_W +: DATA_W];
         out_prio  <= in_prio[g_idx*PRIO_W +: PRIO_W];
         rr_ptr    <= (g_idx == IDX_W'(N_CH - 1)) ? '0 : g_idx + 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Losers that keep requesting age up to the limit; the winner and idle channels restart at zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < N_CH; i++) age[i] <= '0;
      end else if (load) begin
         for (int i = 0; i < N_CH; i++) begin
            if (IDX_W'(i) == g_idx)
               age[i] <= '0;
            else if (in_valid[i])
               age[i] <= (age[i] == AGE_MAX) ? AGE_MAX : age[i] + 1'b1;
            else
               age[i] <= '0;
         end
      end
   end

endmodule

// File: tb/tb_prio_arbiter_pipe.sv
// Directed and random checks of prio_arbiter_pipe against a per-cycle behavioural model.
module tb_prio_arbiter_pipe;

   localparam int N   = 8;
   localparam int DW  = 8;
   localparam int PW  = 8;
   localparam int AGE = 3;
   localparam int IW  = 3;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            mode;
   logic [N-1:0]    in_valid;
   logic [N*DW-1:0] in_data;
   logic [N*PW-1:0] in_prio;
   logic [N-1:0]    in_ready;
   logic            out_valid;
   logic [IW-1:0]   out_idx;
   logic [DW-1:0]   out_data;
   logic [PW-1:0]   out_prio;
   logic            out_ready;

   int n_checks = 0;
   int n_fail   = 0;

   int   m_age [N];
   int   m_rr;
   logic m_ov;
   int   m_idx, m_data, m_prio;
   int   exp_g;
   bit   exp_load;

   prio_arbiter_pipe #(.N_CH(N), .DATA_W(DW), .PRIO_W(PW), .AGE_LIMIT(AGE)) dut (
      .clk(clk), .reset_n(reset_n), .mode(mode),
      .in_valid(in_valid), .in_data(in_data), .in_prio(in_prio), .in_ready(in_ready),
      .out_valid(out_valid), .out_idx(out_idx), .out_data(out_data), .out_prio(out_prio),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_age[i] = 0;
      m_rr = 0; m_ov = 1'b0; m_idx = 0; m_data = 0; m_prio = 0;
   endtask

   // Highest urgency wins; aged requesters preempt everyone and go in circular order.
   function automatic int model_select();
      int  maxp = 0;
      bit  any_aged = 0;
      bit  cand [N];
      bit  rr;
      for (int i = 0; i < N; i++) begin
         if (in_valid[i] && m_age[i] == AGE) any_aged = 1;
         if (in_valid[i] && int'(in_prio[i*PW +: PW]) > maxp) maxp = int'(in_prio[i*PW +: PW]);
      end
      for (int i = 0; i < N; i++)
         cand[i] = any_aged ? (in_valid[i] && m_age[i] == AGE)
                            : (in_valid[i] && int'(in_prio[i*PW +: PW]) == maxp);
      rr = any_aged || mode;
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = rr ? (m_rr + k) % N : k;
         if (cand[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic cycle(input string tag);
      @(negedge clk);
      exp_g    = model_select();
      exp_load = (exp_g >= 0) && (!m_ov || out_ready);
      check({tag, ".in_ready"}, 64'(in_ready), exp_load ? (64'd1 << exp_g) : 64'd0);
      @(posedge clk);
      #1;
      if (exp_load) begin
         for (int i = 0; i < N; i++) begin
            if (i == exp_g)       m_age[i] = 0;
            else if (in_valid[i]) m_age[i] = (m_age[i] + 1 > AGE) ? AGE : m_age[i] + 1;
            else                  m_age[i] = 0;
         end
         m_ov   = 1'b1;
         m_idx  = exp_g;
         m_data = int'(in_data[exp_g*DW +: DW]);
         m_prio = int'(in_prio[exp_g*PW +: PW]);
         m_rr   = (exp_g + 1) % N;
      end else if (m_ov && out_ready) begin
         m_ov = 1'b0;
      end
      check({tag, ".out_valid"}, 64'(out_valid), 64'(m_ov));
      check({tag, ".out_idx"},   64'(out_idx),   64'(m_idx));
      check({tag, ".out_data"},  64'(out_data),  64'(m_data));
      check({tag, ".out_prio"},  64'(out_prio),  64'(m_prio));
   endtask

   task automatic set_ch(input int i, input bit v, input int d, input int p);
      in_valid[i]          = v;
      in_data[i*DW +: DW]  = DW'(d);
      in_prio[i*PW +: PW]  = PW'(p);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      // Reset with every channel requesting
      reset_n = 1'b0; mode = 1'b0; out_ready = 1'b1;
      in_valid = '1; in_data = '0; in_prio = '0;
      for (int i = 0; i < N; i++) set_ch(i, 1, 8'h10 + i, 0);
      model_reset();
      #12;
      check("rst.in_ready",  64'(in_ready),  64'd0);
      check("rst.out_valid", 64'(out_valid), 64'd0);
      check("rst.out_idx",   64'(out_idx),   64'd0);
      check("rst.out_data",  64'(out_data),  64'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      cycle("rst_first");
      check("rst_first.idx", 64'(out_idx), 64'd0);

      // Strict priority with a tie between 6 and 7
      in_valid = '0;
      cycle("drain0");
      set_ch(2, 1, 8'hA2, 5); set_ch(6, 1, 8'hA6, 9); set_ch(7, 1, 8'hA7, 9);
      mode = 1'b0;
      cycle("prio1");
      check("prio1.idx", 64'(out_idx), 64'd6);
      check("prio1.prio", 64'(out_prio), 64'd9);
      in_valid[6] = 1'b0;
      cycle("prio2");
      check("prio2.idx", 64'(out_idx), 64'd7);
      in_valid[7] = 1'b0;
      cycle("prio3");
      check("prio3.idx", 64'(out_idx), 64'd2);
      in_valid = '0;
      cycle("drain1");

      // Round-robin over all equal-priority channels with wrap
      do_reset();
      mode = 1'b1;
      for (int i = 0; i < N; i++) set_ch(i, 1, 8'h30 + i, 0);
      for (int k = 0; k < 9; k++) begin
         cycle("rr");
         check("rr.idx", 64'(out_idx), 64'(k % N));
      end

      // Backpressure holds the output and blocks all inputs
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         cycle("bp");
         check("bp.in_ready", 64'(in_ready), 64'd0);
         check("bp.idx", 64'(out_idx), 64'd0);
      end
      out_ready = 1'b1;
      cycle("bp_release");
      check("bp_release.idx", 64'(out_idx), 64'd1);

      // Starvation guard with AGE=3
      do_reset();
      mode = 1'b0;
      in_valid = '0;
      set_ch(0, 1, 8'h50, 1); set_ch(5, 1, 8'h55, 200);
      for (int k = 0; k < 8; k++) begin
         cycle("starve");
         check("starve.idx", 64'(out_idx), (k % 4 == 3) ? 64'd0 : 64'd5);
      end

      // Asynchronous reset while an output is held
      out_ready = 1'b0;
      cycle("hold");
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      check("areset.out_valid", 64'(out_valid), 64'd0);
      check("areset.in_ready",  64'(in_ready),  64'd0);
      check("areset.out_idx",   64'(out_idx),   64'd0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      mode = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < N; i++) set_ch(i, 1, 8'h70 + i, 0);
      cycle("areset_first");
      check("areset_first.idx", 64'(out_idx), 64'd0);
      cycle("areset_second");
      check("areset_second.idx", 64'(out_idx), 64'd1);

      // Random traffic against the model
      for (int k = 0; k < 400; k++) begin
         in_valid = N'($urandom);
         for (int i = 0; i < N; i++) begin
            in_data[i*DW +: DW] = DW'($urandom);
            in_prio[i*PW +: PW] = PW'($urandom_range(0, 3));
         end
         mode      = 1'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         cycle("rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
